// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host-side logic (transmitter and receiver).
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_state_t;

  // Bits shifted out after the start bit: data[7:0], parity, stop.
  localparam int FRAME_LEN = 10;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  function automatic logic [FRAME_LEN-1:0] make_frame(input logic [7:0] data);
    return {1'b1, odd_parity(data), data};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pins plus a registered
// falling-edge strobe on the synced clock. Reset value 1 matches an idle line.
module ps2_line_sync (
  input  logic clock50,
  input  logic reset_n,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic [1:0] pin_raw;
  logic [1:0] pin_sync;
  logic       clk_prev_reg;

  assign pin_raw = {ps2_data_in, ps2_clk_in};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;

      always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
        end else begin
          meta_reg <= pin_raw[gi];
          sync_reg <= meta_reg;
        end
      end

      assign pin_sync[gi] = sync_reg;
    end
  endgenerate

  assign clk_sync  = pin_sync[0];
  assign data_sync = pin_sync[1];

  // The fall strobe is registered, so consumers see it one cycle after detection.
  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      clk_prev_reg <= 1'b1;
      clk_fall     <= 1'b0;
    end else begin
      clk_prev_reg <= pin_sync[0];
      clk_fall     <= clk_prev_reg & ~pin_sync[0];
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift out one
// odd-parity frame on device clock falls, then check the device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int REQ_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clock50,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int PHASE_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int CW        = $clog2(PHASE_MAX + 1);
  localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_t           state_reg;
  logic [CW-1:0]        phase_cnt_reg;
  logic [TW-1:0]        timeout_cnt_reg;
  logic [FRAME_LEN-1:0] shift_reg;
  logic [3:0]           bit_idx_reg;

  logic clk_sync;
  logic data_sync;
  logic clk_fall;

  ps2_line_sync u_sync (
    .clock50     (clock50),
    .reset_n     (reset_n),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .clk_sync    (clk_sync),
    .data_sync   (data_sync),
    .clk_fall    (clk_fall)
  );

  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      phase_cnt_reg   <= '0;
      timeout_cnt_reg <= '0;
      shift_reg       <= '0;
      bit_idx_reg     <= '0;
      tx_busy         <= 1'b0;
      tx_done         <= 1'b0;
      tx_error        <= 1'b0;
      ps2_clk_oe      <= 1'b0;
      ps2_data_oe     <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state_reg)
        IDLE: begin
          // A start coinciding with the end-of-frame pulse is dropped.
          if (tx_start && !tx_done && !tx_error) begin
            shift_reg     <= make_frame(tx_data);
            phase_cnt_reg <= '0;
            tx_busy       <= 1'b1;
            ps2_clk_oe    <= 1'b1;
            state_reg     <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (phase_cnt_reg == CW'(INHIBIT_CYCLES - 1)) begin
            phase_cnt_reg <= '0;
            ps2_data_oe   <= 1'b1;
            state_reg     <= REQ;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 1'b1;
          end
        end
        REQ: begin
          if (phase_cnt_reg == CW'(REQ_CYCLES - 1)) begin
            ps2_clk_oe      <= 1'b0;
            timeout_cnt_reg <= '0;
            bit_idx_reg     <= '0;
            state_reg       <= SEND;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 1'b1;
          end
        end
        SEND, ACK, WAIT_IDLE: begin
          if (timeout_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_busy     <= 1'b0;
            tx_error    <= 1'b1;
            state_reg   <= IDLE;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
            if (state_reg == SEND && clk_fall) begin
              ps2_data_oe <= ~shift_reg[0];
              shift_reg   <= {1'b0, shift_reg[FRAME_LEN-1:1]};
              bit_idx_reg <= bit_idx_reg + 1'b1;
              if (bit_idx_reg == 4'(FRAME_LEN - 1)) state_reg <= ACK;
            end else if (state_reg == ACK && clk_fall) begin
              if (!data_sync) begin
                state_reg <= WAIT_IDLE;
              end else begin
                tx_busy   <= 1'b0;
                tx_error  <= 1'b1;
                state_reg <= IDLE;
              end
            end else if (state_reg == WAIT_IDLE && clk_sync && data_sync) begin
              tx_busy   <= 1'b0;
              tx_done   <= 1'b1;
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain line and a simple PS/2
// device model that clocks the frame in and optionally ACKs.
module tb_ps2_host_tx;

  localparam int HALF = 20;

  logic       clock50 = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       clk_line, data_line;

  assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (5000),
    .REQ_CYCLES     (50),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .clock50     (clock50),
    .reset_n     (reset_n),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_error    (tx_error),
    .ps2_clk_in  (clk_line),
    .ps2_data_in (data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #10 clock50 = ~clock50;

  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  always @(negedge clock50) begin
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
    if (tx_done && tx_error) both_cnt++;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic start_tx(input logic [7:0] d);
    @(negedge clock50);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clock50);
    tx_start = 1'b0;
  endtask

  task automatic measure_req(output int n_inh, output int n_req);
    n_inh = 0;
    n_req = 0;
    while (ps2_clk_oe && !ps2_data_oe && n_inh < 20000) begin
      n_inh++;
      @(negedge clock50);
    end
    while (ps2_clk_oe && ps2_data_oe && n_req < 1000) begin
      n_req++;
      @(negedge clock50);
    end
  endtask

  task automatic wait_send(input string tag);
    int b = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1 && tx_busy) && b < 20000) begin
      @(negedge clock50);
      b++;
    end
    check({tag, "_send_entry"}, {31'd0, (ps2_data_oe && !ps2_clk_oe)}, 32'd1);
  endtask

  // Device clocks the frame in, sampling each bit while its clock is high.
  task automatic device_frame(input string tag, input bit ack, input int abort_fall,
                              output logic [10:0] bits);
    bits = '0;
    wait_send(tag);
    repeat (HALF) @(negedge clock50);
    bits[0] = data_line;
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      if (i == abort_fall) begin
        repeat (8) @(negedge clock50);
        check({tag, "_pre_reset_data_oe"}, {31'd0, ps2_data_oe}, 32'd1);
        check({tag, "_pre_reset_busy"}, {31'd0, tx_busy}, 32'd1);
        #3 reset_n = 1'b0;
        #1;
        check({tag, "_rst_clk_oe"}, {31'd0, ps2_clk_oe}, 32'd0);
        check({tag, "_rst_data_oe"}, {31'd0, ps2_data_oe}, 32'd0);
        check({tag, "_rst_busy"}, {31'd0, tx_busy}, 32'd0);
        dev_clk_low = 1'b0;
        return;
      end
      repeat (HALF) @(negedge clock50);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clock50);
      bits[i] = data_line;
    end
    dev_data_low = ack;
    repeat (HALF) @(negedge clock50);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clock50);
    dev_clk_low = 1'b0;
    repeat (HALF) @(negedge clock50);
    dev_data_low = 1'b0;
  endtask

  task automatic check_end(input string tag, input int d0, input int e0,
                           input int exp_done, input int exp_err);
    repeat (HALF + 10) @(negedge clock50);
    check({tag, "_done"}, done_cnt - d0, exp_done);
    check({tag, "_error"}, err_cnt - e0, exp_err);
    check({tag, "_busy"}, {31'd0, tx_busy}, 32'd0);
    check({tag, "_oe"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
  endtask

  // Full acknowledged frame; exp_bits is {stop, parity, data, start}.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic [10:0] exp_bits);
    int d0, e0;
    logic [10:0] bits;
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(d);
    device_frame(tag, 1'b1, 0, bits);
    check({tag, "_bits"}, {21'd0, bits}, {21'd0, exp_bits});
    check_end(tag, d0, e0, 1, 0);
    $display("frame %s data=0x%02h line=%b done=%0d", tag, d, bits, done_cnt - d0);
  endtask

  initial begin
    int n_inh, n_req, d0, e0, n;
    logic [10:0] bits;

    repeat (5) @(negedge clock50);
    check("reset_busy", {31'd0, tx_busy}, 32'd0);
    check("reset_done", {31'd0, tx_done}, 32'd0);
    check("reset_error", {31'd0, tx_error}, 32'd0);
    check("reset_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock50);

    // 0xED with inhibit/request timing measured; 0xED has six ones -> parity 1.
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'hED);
    measure_req(n_inh, n_req);
    check("ed_inhibit_len", n_inh, 5000);
    check("ed_req_len", n_req, 50);
    device_frame("ed", 1'b1, 0, bits);
    check("ed_bits", {21'd0, bits}, {21'd0, 11'b1_1_11101101_0});
    check_end("ed", d0, e0, 1, 0);
    $display("frame ed data=0xED inhibit=%0d req=%0d line=%b", n_inh, n_req, bits);

    run_frame("x01", 8'h01, 11'b1_0_00000001_0);
    run_frame("x00", 8'h00, 11'b1_1_00000000_0);

    // Device does not ACK.
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'hFF);
    device_frame("ff", 1'b0, 0, bits);
    check("ff_bits", {21'd0, bits}, {21'd0, 11'b1_1_11111111_0});
    check_end("ff_noack", d0, e0, 0, 1);
    $display("frame ff no-ack line=%b error=%0d", bits, err_cnt - e0);

    // Device never clocks: error 1000 cycles after SEND entry.
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'h12);
    wait_send("tmo");
    n = 0;
    while (!tx_error && n < 5000) begin
      @(negedge clock50);
      n++;
    end
    check("tmo_latency", n, 1000);
    check("tmo_oe_at_error", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check_end("tmo", d0, e0, 0, 1);
    $display("frame timeout latency=%0d", n);

    // Reset during fall 5 of a 0x0F frame (D4=0 is being driven low).
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'h0F);
    device_frame("rst", 1'b1, 5, bits);
    repeat (10) @(negedge clock50);
    reset_n = 1'b1;
    repeat (10) @(negedge clock50);
    check("rst_no_done", done_cnt - d0, 0);
    check("rst_no_error", err_cnt - e0, 0);
    $display("frame 0x0F aborted by reset at fall 5");
    run_frame("x55", 8'h55, 11'b1_1_01010101_0);

    // Second start while busy must not disturb 0x3C.
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'h3C);
    repeat (100) @(negedge clock50);
    start_tx(8'hAA);
    device_frame("ign", 1'b1, 0, bits);
    check("ign_bits", {21'd0, bits}, {21'd0, 11'b1_1_00111100_0});
    check_end("ign", d0, e0, 1, 0);
    $display("frame 3C with ignored AA start line=%b", bits);

    check("never_both", both_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
